// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory port arbiter: FSM state
//   encoding, default port widths and the starvation counter width.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W   = 32;
  localparam int ARB_DATA_W   = 32;
  // Wide enough for the largest allowed STARVE_LIMIT (15).
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
//   Counts data grants made while a fetch is waiting and raises if_priority
//   once STARVE_LIMIT of them have gone by, so a held fetch cannot be
//   locked out by a stream of loads/stores.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   idle         arbiter is in its arbitration state this cycle
//   if_req       fetch request (raw, before flush masking)
//   data_grant   a data access is granted this cycle
//   fetch_grant  a fetch is granted this cycle
//   if_priority  fetch must win the next contested arbitration
module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_req,
  input  logic data_grant,
  input  logic fetch_grant,
  output logic if_priority
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt;

  // Clearing wins over counting: an idle cycle without a fetch request means
  // nobody is starving, even if a data access is granted in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fetch_grant || (idle && !if_req)) begin
      starve_cnt <= '0;
    end else if (data_grant && if_req && (starve_cnt != '1)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign if_priority = (starve_cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (read-only) and the
//   MEM stage (loads/stores). One transaction is outstanding at a time; the
//   completing requester gets a one-cycle ready pulse with registered data.
//   The ready cycle is an arbitration cycle: requesters are expected to
//   present their next request (or drop req) in the cycle ready is high.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   if_req/if_addr/if_flush            fetch request, PC, redirect/cancel
//   if_ready/if_rdata/if_stall         fetch completion pulse, data, stall
//   d_req/d_we/d_addr/d_wdata/d_be     data request (load/store)
//   d_ready/d_rdata/d_stall            data completion pulse, data, stall
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  request to memory wrapper
//   mem_ready/mem_rdata                memory completion and read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state, state_nxt;
  logic       kill;
  logic       idle;
  logic       fetch_elig;
  logic       if_priority;
  logic       data_win;
  logic       fetch_win;

  assign idle       = (state == ARB_IDLE);
  assign fetch_elig = if_req & ~if_flush;
  // Data goes first unless a fetch is eligible and has waited long enough.
  assign data_win   = idle & d_req & (~fetch_elig | ~if_priority);
  assign fetch_win  = idle & fetch_elig & ~data_win;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle        (idle),
    .if_req      (if_req),
    .data_grant  (data_win),
    .fetch_grant (fetch_win),
    .if_priority (if_priority)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (data_win) begin
          state_nxt = ARB_BUSY_D;
        end else if (fetch_win) begin
          state_nxt = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_ready) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      kill      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (data_win) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
          end else if (fetch_win) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_be   <= '1;
          end
        end
        ARB_BUSY_I: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            kill    <= 1'b0;
            // A redirect arriving in the completion cycle cancels it too.
            if (!kill && !if_flush) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            kill <= 1'b1;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            d_rdata <= mem_rdata;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

  assign if_stall = if_req & ~if_ready;
  assign d_stall  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks;
  int errors;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    d_be      = 4'hF;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  // ---------------- behavioural reference model ----------------
  // Transaction view: who owns the port (0 none, 1 fetch, 2 data), how many
  // data grants a waiting fetch has watched go by, and the last values
  // handed to each side.
  int          m_owner;
  int          m_waited;
  bit          m_cancelled;
  logic        m_req, m_we, m_ir, m_dr;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [3:0]  m_be;

  task automatic model_reset();
    m_owner = 0; m_waited = 0; m_cancelled = 0;
    m_req = 0; m_we = 0; m_ir = 0; m_dr = 0;
    m_addr = 0; m_wdata = 0; m_ird = 0; m_drd = 0; m_be = 0;
  endtask

  task automatic model_step();
    bit fetch_ok, give_data, give_fetch;
    m_ir = 0;
    m_dr = 0;
    if (m_owner == 0) begin
      fetch_ok   = if_req && !if_flush;
      give_data  = d_req && (!fetch_ok || m_waited < LIMIT);
      give_fetch = fetch_ok && !give_data;
      if (give_fetch || !if_req) m_waited = 0;
      else if (give_data) m_waited = (m_waited + 1 > 15) ? 15 : m_waited + 1;
      if (give_data) begin
        m_owner = 2; m_req = 1; m_we = d_we;
        m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
      end else if (give_fetch) begin
        m_owner = 1; m_req = 1; m_we = 0;
        m_addr = if_addr; m_be = 4'hF;
      end
    end else if (mem_ready) begin
      if (m_owner == 1 && !m_cancelled && !if_flush) begin
        m_ir = 1; m_ird = mem_rdata;
      end
      if (m_owner == 2) begin
        m_dr = 1; m_drd = mem_rdata;
      end
      m_owner = 0; m_req = 0; m_cancelled = 0;
    end else if (m_owner == 1 && if_flush) begin
      m_cancelled = 1;
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_if_rdy;
    logic        e_d_rdy;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    byte   grants[$];
    string exp_order;
    int    stores_done;
    logic  prev_req;

    checks = 0;
    errors = 0;

    // Single fetch, collision (data first, fetch in d_ready cycle), store.
    vecs[0]  = '{1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,
                 1'b1, 1'b0, 32'h100,  1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    1'b1, 32'h00500093,
                 1'b0, 1'b0, 32'h100,  1'b1, 1'b0, 32'h00500093, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,
                 1'b0, 1'b0, 32'h100,  1'b0, 1'b0, 32'h00500093, 32'h0};
    vecs[3]  = '{1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h00500093, 32'h0};
    vecs[4]  = '{1'b1, 32'h104,  1'b1, 1'b0, 32'h2000, 1'b1, 32'hCAFE0001,
                 1'b0, 1'b0, 32'h2000, 1'b0, 1'b1, 32'h00500093, 32'hCAFE0001};
    vecs[5]  = '{1'b1, 32'h104,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,
                 1'b1, 1'b0, 32'h104,  1'b0, 1'b0, 32'h00500093, 32'hCAFE0001};
    vecs[6]  = '{1'b1, 32'h104,  1'b0, 1'b0, 32'h0,    1'b1, 32'h00A00113,
                 1'b0, 1'b0, 32'h104,  1'b1, 1'b0, 32'h00A00113, 32'hCAFE0001};
    vecs[7]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,
                 1'b0, 1'b0, 32'h104,  1'b0, 1'b0, 32'h00A00113, 32'hCAFE0001};
    vecs[8]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h44,   1'b0, 32'h0,
                 1'b1, 1'b1, 32'h44,   1'b0, 1'b0, 32'h00A00113, 32'hCAFE0001};
    vecs[9]  = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h44,   1'b1, 32'h12345678,
                 1'b0, 1'b1, 32'h44,   1'b0, 1'b1, 32'h00A00113, 32'h12345678};
    vecs[10] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,
                 1'b0, 1'b1, 32'h44,   1'b0, 1'b0, 32'h00A00113, 32'h12345678};

    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk1 ("rst_mem_req",  mem_req, 1'b0);
    chk1 ("rst_mem_we",   mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_be",   32'(mem_be), 32'h0);
    chk1 ("rst_if_ready", if_ready, 1'b0);
    chk1 ("rst_d_ready",  d_ready, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata",  d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      if_req    = vecs[i].if_req;
      if_addr   = vecs[i].if_addr;
      d_req     = vecs[i].d_req;
      d_we      = vecs[i].d_we;
      d_addr    = vecs[i].d_addr;
      mem_ready = vecs[i].mem_ready;
      mem_rdata = vecs[i].mem_rdata;
      tick();
      chk1 ($sformatf("vec%0d_mem_req", i),  mem_req,  vecs[i].e_req);
      chk1 ($sformatf("vec%0d_mem_we", i),   mem_we,   vecs[i].e_we);
      chk32($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk32($sformatf("vec%0d_mem_be", i),   32'(mem_be), 32'hF);
      chk1 ($sformatf("vec%0d_if_ready", i), if_ready, vecs[i].e_if_rdy);
      chk1 ($sformatf("vec%0d_d_ready", i),  d_ready,  vecs[i].e_d_rdy);
      chk32($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk32($sformatf("vec%0d_d_rdata", i),  d_rdata,  vecs[i].e_d_rdata);
    end
    clear_inputs();
    tick();

    // Wait states: store held with mem_ready low for three cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      chk1 ($sformatf("ws%0d_mem_req", i),   mem_req, 1'b1);
      chk1 ($sformatf("ws%0d_mem_we", i),    mem_we, 1'b1);
      chk32($sformatf("ws%0d_mem_addr", i),  mem_addr, 32'h40);
      chk32($sformatf("ws%0d_mem_wdata", i), mem_wdata, 32'hDEADBEEF);
      chk32($sformatf("ws%0d_mem_be", i),    32'(mem_be), 32'h3);
      chk1 ($sformatf("ws%0d_d_ready", i),   d_ready, 1'b0);
      tick();
    end
    clear_inputs();
    chk1("ws_d_ready_pulse", d_ready, 1'b1);
    chk1("ws_mem_req_drop",  mem_req, 1'b0);
    tick();
    chk1("ws_d_ready_once",  d_ready, 1'b0);

    // Starvation: fetch held against six back-to-back stores.
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'h11; d_be = 4'hF;
    mem_rdata = 32'h51510000;
    stores_done = 0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 120 && stores_done < 6; cyc++) begin
      tick();
      mem_ready = mem_req;
      if (mem_req && !prev_req) grants.push_back(mem_we ? 8'h44 : 8'h49);
      prev_req = mem_req;
      if (d_ready) begin
        stores_done++;
        if (stores_done == 6) d_req = 1'b0;
        else begin
          d_addr  = d_addr + 32'd4;
          d_wdata = d_wdata + 32'd1;
        end
      end
      if (if_ready) if_addr = if_addr + 32'd4;
    end
    chk32("starve_stores_done", 32'(stores_done), 32'd6);
    exp_order = "DDDDIDD";
    for (int i = 0; i < 7; i++) begin
      if (i < grants.size()) chk32($sformatf("starve_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));
      else chk32($sformatf("starve_grant%0d_missing", i), 32'(grants.size()), 32'd7);
    end
    if_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ready = mem_req;
    end
    clear_inputs();
    tick();
    chk1 ("starve_drained",   mem_req, 1'b0);
    chk32("starve_if_rdata",  if_rdata, 32'h51510000);

    // Flush in IDLE blocks the grant; flush in BUSY_I kills if_ready.
    if_req = 1'b1; if_addr = 32'h200; if_flush = 1'b1;
    tick();
    chk1("flush_idle_no_grant", mem_req, 1'b0);
    if_flush = 1'b0;
    tick();
    chk1 ("flush_fetch_granted", mem_req, 1'b1);
    chk32("flush_fetch_addr",    mem_addr, 32'h200);
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ready = 1'b0;
    chk1 ("flush_no_if_ready", if_ready, 1'b0);
    chk32("flush_if_rdata",    if_rdata, 32'h51510000);
    chk1 ("flush_mem_req_low", mem_req, 1'b0);
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    chk1 ("refetch_req",  mem_req, 1'b1);
    chk32("refetch_addr", mem_addr, 32'h300);
    mem_ready = 1'b1; mem_rdata = 32'h00300093;
    tick();
    chk1 ("refetch_if_ready", if_ready, 1'b1);
    chk32("refetch_if_rdata", if_rdata, 32'h00300093);
    clear_inputs();
    tick();
    chk1("refetch_pulse_once", if_ready, 1'b0);

    // Asynchronous reset in the middle of a data access.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick();
    chk1("rmid_busy", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("rmid_mem_req", mem_req, 1'b0);
    chk1 ("rmid_d_ready", d_ready, 1'b0);
    chk32("rmid_mem_addr", mem_addr, 32'h0);
    clear_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    d_req = 1'b1; d_addr = 32'h84;
    tick();
    chk1 ("rpost_req",  mem_req, 1'b1);
    chk32("rpost_addr", mem_addr, 32'h84);
    mem_ready = 1'b1; mem_rdata = 32'h77;
    tick();
    chk1 ("rpost_d_ready", d_ready, 1'b1);
    chk32("rpost_d_rdata", d_rdata, 32'h77);
    clear_inputs();
    tick();

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int n = 0; n < 600; n++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      if_addr   = $urandom;
      if_flush  = ($urandom_range(0, 7) == 0);
      d_req     = ($urandom_range(0, 1) == 0);
      d_we      = ($urandom_range(0, 1) == 0);
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_be      = 4'($urandom);
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      @(posedge clk);
      model_step();
      #1;
      chk1 ($sformatf("rnd%0d_mem_req", n),   mem_req,   m_req);
      chk1 ($sformatf("rnd%0d_mem_we", n),    mem_we,    m_we);
      chk32($sformatf("rnd%0d_mem_addr", n),  mem_addr,  m_addr);
      chk32($sformatf("rnd%0d_mem_wdata", n), mem_wdata, m_wdata);
      chk32($sformatf("rnd%0d_mem_be", n),    32'(mem_be), 32'(m_be));
      chk1 ($sformatf("rnd%0d_if_ready", n),  if_ready,  m_ir);
      chk1 ($sformatf("rnd%0d_d_ready", n),   d_ready,   m_dr);
      chk32($sformatf("rnd%0d_if_rdata", n),  if_rdata,  m_ird);
      chk32($sformatf("rnd%0d_d_rdata", n),   d_rdata,   m_drd);
      chk1 ($sformatf("rnd%0d_if_stall", n),  if_stall,  if_req & ~m_ir);
      chk1 ($sformatf("rnd%0d_d_stall", n),   d_stall,   d_req & ~m_dr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified instruction/data memory port between the IF stage (fetch, read-only) and the MEM stage (loads/stores, driven by the decoder's MemRead/MemWrite).
- Arbitrates between the two, sequences one outstanding memory transaction at a time, and returns read data with a one-cycle ready pulse.
- Exposes stall signals to the pipeline control. Sits between the pipeline and the memory wrapper.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits. Must be a multiple of 8.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request. Held until if_ready or if_flush.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  branch/jump redirect; cancels pending or in-flight fetch.
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- if_stall  out  1  if_req & ~if_ready.
- d_req  in  1  data request (MemRead | MemWrite). Held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_ready  out  1  one-cycle pulse: load data valid / store done.
- d_rdata  out  DATA_W  load data.
- d_stall  out  1  d_req & ~d_ready.
- mem_req  out  1  memory request. Held until mem_ready.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables.
- mem_ready  in  1  memory completion. Read data valid this cycle.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE; mem_req, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, mem_be, if_rdata, d_rdata = 0; starve_cnt = 0; kill = 0.
- States:
  - IDLE: arbitrate.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
- Arbitration in IDLE, evaluated each cycle:
  - Eligible fetch = if_req & ~if_flush.
  - Data wins if d_req and (no eligible fetch or starve_cnt < STARVE_LIMIT). Otherwise an eligible fetch wins.
  - The winner's address, data, be and we are registered onto mem_*; mem_req <= 1; state moves to BUSY_D or BUSY_I.
  - Fetch grants drive mem_we = 0 and mem_be = all ones.
- starve_cnt:
  - +1 (saturating) on each data grant made while if_req is high.
  - Cleared on any fetch grant, or in any IDLE cycle with if_req low.
- BUSY_x:
  - mem_* are held stable while mem_ready = 0. There is no timeout.
  - On a cycle with mem_ready = 1: mem_req <= 0, state <= IDLE, rdata registered, and the matching x_ready <= 1 for exactly one cycle.
- Latency (zero-wait memory):
  - Request in cycle 0 → mem_req in cycle 1; mem_ready in cycle 1 → x_ready in cycle 2.
  - The ready cycle is always IDLE, so back-to-back transactions have a one-cycle bubble.
  - Because the requester samples ready and drops req at that edge, the same request is never re-granted.
- Flush:
  - if_flush in IDLE blocks the fetch grant that cycle.
  - if_flush while BUSY_I sets kill. The transaction still completes on mem_ready, but if_ready is suppressed.
  - kill is cleared on completion.
  - if_flush in BUSY_D has no effect on the data access.
- Simultaneous d_req and if_req with starve_cnt = STARVE_LIMIT: fetch wins.
- d_rdata is updated only on data completion; if_rdata only on non-killed fetch completion. Both hold otherwise.
- Stores: d_rdata is updated with mem_rdata (don't-care); d_ready still pulses.
- Reset asserted mid-transaction: immediate return to IDLE with mem_req = 0. The memory wrapper must also be reset by rst_n.

Decomposition:
- Shared package:
  - state encoding (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D);
  - default widths ADDR_W and DATA_W (same values as the existing Params header).
- One natural sub-module: mem_arb_starve_ctr (saturating counter plus compare against STARVE_LIMIT, giving if_priority).
- FSM and datapath registers stay in the top module.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x100, mem_ready = 1 at cycle 1, mem_rdata = 0x00500093 → if_ready = 1 at cycle 2 with if_rdata = 0x00500093; mem_we = 0, mem_be = 4'hF.
- Collision: if_req and d_req (load 0x2000) both rise at cycle 0, starve_cnt = 0 → data granted first (mem_addr = 0x2000). Fetch is granted in the IDLE cycle after d_ready.
- Starvation: if_req held, d_req held with 6 back-to-back stores, STARVE_LIMIT = 4 → grant order D, D, D, D, I, D, D.
- Wait states: store d_addr = 0x40, d_wdata = 0xDEADBEEF, d_be = 4'b0011, mem_ready low for 3 cycles → mem_* stable for 4 cycles; d_ready pulses once, the cycle after mem_ready.
- Flush in flight: fetch 0x200 granted, if_flush = 1 in BUSY_I, mem_ready 2 cycles later → no if_ready pulse, if_rdata unchanged. The next fetch at 0x300 completes normally.
- Reset mid-op: rst_n low during BUSY_D → mem_req = 0 and d_ready = 0 immediately (asynchronous); after release, a new load completes with 2-cycle latency.
